// File: rtl/hif_queue_reader.sv
// hif_queue_reader: consumer side of the circular sample queue. Each accepted
// write trigger sweeps the newest TAPS samples out of the queue RAM, multiplies
// them against a coefficient ROM, and emits one saturated filtered sample.
module hif_queue_reader #(
   parameter int DEPTH = 1536,
   parameter int AW    = 11,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int TAPS  = 1021
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wrt_smpl,
   input  logic [AW-1:0] wr_ptr,
   input  logic          q_full,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] rdata,
   output logic [AW-1:0] caddr,
   input  logic [CW-1:0] cdata,
   output logic          busy,
   output logic [DW-1:0] smpl_out,
   output logic          vld,
   output logic          overrun
);

   localparam int PW    = DW + CW;
   localparam int ACC_W = DW + CW + AW;

   localparam logic [AW-1:0] TAPS_M1  = AW'(TAPS - 1);
   localparam logic [AW-1:0] DEPTH_M1 = AW'(DEPTH - 1);
   // Modular offset; truncation is harmless when DEPTH == 2**AW.
   localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DW-1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, OUT} state_t;

   state_t                   state, state_nxt;
   logic                     trigger;
   logic                     last_tap;
   logic                     drain_done;
   logic [AW-1:0]            start;
   logic                     v0, v1, v2;
   logic signed [DW-1:0]     s1_smpl;
   logic signed [CW-1:0]     s1_coef;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_shr;
   logic [DW-1:0]            sat;

   assign busy       = (state != IDLE);
   assign last_tap   = (caddr == TAPS_M1);
   // Only the final product remains in flight: it lands in acc this edge.
   assign drain_done = v2 & ~v1 & ~v0;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and trigger decode.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_nxt = state;
      trigger   = 1'b0;
      unique case (state)
         IDLE: if (wrt_smpl && q_full) begin
            trigger   = 1'b1;
            state_nxt = SWEEP;
         end
         SWEEP: if (last_tap)   state_nxt = DRAIN;
         DRAIN: if (drain_done) state_nxt = OUT;
         OUT:                   state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // Oldest sample of the window, modulo the queue depth.
   always_comb begin
      if (wr_ptr >= TAPS_M1) start = wr_ptr - TAPS_M1;
      else                   start = wr_ptr + DEPTH_AW - TAPS_M1;
   end

   // Address generation: queue pointer wraps at DEPTH, ROM address is the tap index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raddr <= '0;
         caddr <= '0;
      end else if (trigger) begin
         raddr <= start;
         caddr <= '0;
      end else if (state == SWEEP && !last_tap) begin
         raddr <= (raddr == DEPTH_M1) ? '0 : raddr + AW'(1);
         caddr <= caddr + AW'(1);
      end
   end

   // Valid tags that follow each issued address down the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v0 <= (state == SWEEP);
         v1 <= v0;
         v2 <= v1;
      end
   end

   // Operand and product registers; contents are qualified by the valid tags.
   always_ff @(posedge clk) begin
      // NOTE: pure datapath registers carry no reset; the valid tags gate them.
      s1_smpl <= rdata;
      s1_coef <= cdata;
      prod    <= s1_smpl * s1_coef;
   end

   // Accumulator, cleared at trigger; wide enough that it never overflows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          acc <= '0;
      else if (trigger) acc <= '0;
      else if (v2)      acc <= acc + {{AW{prod[PW-1]}}, prod};
   end

   // Rescale from Q1.(CW-1) with floor, then clamp to the sample range.
   always_comb begin
      acc_shr = acc >>> (CW - 1);
      if (acc_shr > SAT_MAX)      sat = {1'b1, {(DW-1){1'b0}}} ^ {DW{1'b1}};
      else if (acc_shr < SAT_MIN) sat = {1'b1, {(DW-1){1'b0}}};
      else                        sat = acc_shr[DW-1:0];
   end

   // Result register, valid pulse and sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smpl_out <= '0;
         vld      <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         vld <= (state == OUT);
         if (state == OUT)     smpl_out <= sat;
         if (wrt_smpl && busy) overrun  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hif_queue_reader.sv
// Self-checking bench for hif_queue_reader with DEPTH=16, TAPS=4. Expected
// results come from a direct windowed dot product over the RAM/ROM contents.
module tb_hif_queue_reader;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int TAPS  = 4;
   localparam int OBS   = 20;

   logic          clk;
   logic          rst;
   logic          wrt_smpl;
   logic [AW-1:0] wr_ptr;
   logic          q_full;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;
   logic [AW-1:0] caddr;
   logic [CW-1:0] cdata;
   logic          busy;
   logic [DW-1:0] smpl_out;
   logic          vld;
   logic          overrun;

   logic [DW-1:0] ram  [DEPTH];
   logic [CW-1:0] coef [DEPTH];

   int checks;
   int errors;

   // Observations of the most recent sweep.
   logic [AW-1:0] obs_raddr [TAPS];
   logic [AW-1:0] obs_caddr [TAPS];
   logic          obs_busy0;
   int            vld_at;
   int            vld_cnt;
   logic [DW-1:0] got;

   hif_queue_reader #(
      .DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW), .TAPS(TAPS)
   ) dut (
      .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .wr_ptr(wr_ptr),
      .q_full(q_full), .raddr(raddr), .rdata(rdata), .caddr(caddr),
      .cdata(cdata), .busy(busy), .smpl_out(smpl_out), .vld(vld),
      .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue RAM and coefficient ROM, both one-clock read latency.
   always @(posedge clk) begin
      rdata <= ram[raddr];
      cdata <= coef[caddr];
   end

   function automatic int model_start(input int wp);
      return (wp - (TAPS - 1) + DEPTH) % DEPTH;
   endfunction

   function automatic logic [DW-1:0] model_out(input int wp);
      longint acc;
      longint shr;
      int     idx;
      acc = 0;
      for (int i = 0; i < TAPS; i++) begin
         idx = (wp - (TAPS - 1) + i + DEPTH) % DEPTH;
         acc += longint'($signed(ram[idx])) * longint'($signed(coef[i]));
      end
      shr = acc >>> (CW - 1);
      if (shr > 32767)  return 16'h7fff;
      if (shr < -32768) return 16'h8000;
      return shr[DW-1:0];
   endfunction

   // Trigger one sweep and record what the DUT does for OBS clocks afterwards.
   // second_at >= 0 raises wrt_smpl again at that observation slot.
   task automatic run_sweep(input logic [AW-1:0] wp, input int second_at);
      @(negedge clk);
      wr_ptr   = wp;
      wrt_smpl = 1'b1;
      vld_at   = -1;
      vld_cnt  = 0;
      got      = '0;
      for (int j = 0; j < OBS; j++) begin
         @(negedge clk);
         if (j < TAPS) begin
            obs_raddr[j] = raddr;
            obs_caddr[j] = caddr;
         end
         if (j == 0) obs_busy0 = busy;
         if (vld === 1'b1) begin
            if (vld_at < 0) vld_at = j;
            vld_cnt++;
            got = smpl_out;
         end
         wrt_smpl = (j == second_at);
         wr_ptr   = AW'($urandom_range(DEPTH - 1));
      end
      wrt_smpl = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (raddr !== '0)    begin errors++; $display("FAIL reset_raddr got %h expected 0", raddr); end
      checks++; if (caddr !== '0)    begin errors++; $display("FAIL reset_caddr got %h expected 0", caddr); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (smpl_out !== '0) begin errors++; $display("FAIL reset_smpl_out got %h expected 0", smpl_out); end
      checks++; if (vld !== 1'b0)    begin errors++; $display("FAIL reset_vld got %b expected 0", vld); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", overrun); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_no_qfull();
      logic seen_busy;
      logic seen_vld;
      seen_busy = 1'b0;
      seen_vld  = 1'b0;
      q_full = 1'b0;
      @(negedge clk);
      wr_ptr   = 4'd5;
      wrt_smpl = 1'b1;
      @(negedge clk);
      wrt_smpl = 1'b0;
      for (int j = 0; j < 12; j++) begin
         if (busy !== 1'b0) seen_busy = 1'b1;
         if (vld !== 1'b0)  seen_vld  = 1'b1;
         @(negedge clk);
      end
      checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL noqfull_busy got 1 expected 0"); end
      checks++; if (seen_vld !== 1'b0)  begin errors++; $display("FAIL noqfull_vld got 1 expected 0"); end
      checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL noqfull_overrun got %b expected 0", overrun); end
      q_full = 1'b1;
   endtask

   task automatic load_basic();
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]  = DW'($urandom);
         coef[i] = CW'($urandom);
      end
      ram[2] = 16'd100; ram[3] = 16'd200; ram[4] = 16'd300; ram[5] = 16'd400;
      for (int i = 0; i < TAPS; i++) coef[i] = 16'h4000;
   endtask

   task automatic test_basic();
      int st;
      load_basic();
      st = model_start(5);
      run_sweep(4'd5, -1);
      for (int i = 0; i < TAPS; i++) begin
         checks++;
         if (obs_raddr[i] !== AW'((st + i) % DEPTH)) begin
            errors++; $display("FAIL basic_raddr[%0d] got %0d expected %0d", i, obs_raddr[i], (st + i) % DEPTH);
         end
         checks++;
         if (obs_caddr[i] !== AW'(i)) begin
            errors++; $display("FAIL basic_caddr[%0d] got %0d expected %0d", i, obs_caddr[i], i);
         end
      end
      checks++; if (obs_busy0 !== 1'b1)  begin errors++; $display("FAIL basic_busy got %b expected 1", obs_busy0); end
      checks++; if (vld_at != TAPS + 4)  begin errors++; $display("FAIL basic_latency got %0d expected %0d", vld_at, TAPS + 4); end
      checks++; if (vld_cnt != 1)        begin errors++; $display("FAIL basic_vld_count got %0d expected 1", vld_cnt); end
      checks++; if (got !== 16'h01f4)    begin errors++; $display("FAIL basic_result got %h expected 01f4", got); end
      checks++; if (smpl_out !== 16'h01f4) begin errors++; $display("FAIL basic_hold got %h expected 01f4", smpl_out); end
      checks++; if (raddr !== 4'd5)      begin errors++; $display("FAIL basic_raddr_idle got %0d expected 5", raddr); end
      checks++; if (caddr !== 4'd3)      begin errors++; $display("FAIL basic_caddr_idle got %0d expected 3", caddr); end
   endtask

   task automatic test_wrap();
      ram[14] = 16'hffff; ram[15] = 16'hffff; ram[0] = 16'hffff; ram[1] = 16'hffff;
      for (int i = 0; i < TAPS; i++) coef[i] = 16'h4000;
      run_sweep(4'd1, -1);
      checks++;
      if (obs_raddr[0] !== 4'd14 || obs_raddr[1] !== 4'd15 || obs_raddr[2] !== 4'd0 || obs_raddr[3] !== 4'd1) begin
         errors++; $display("FAIL wrap_raddr got %0d,%0d,%0d,%0d expected 14,15,0,1",
                            obs_raddr[0], obs_raddr[1], obs_raddr[2], obs_raddr[3]);
      end
      checks++; if (vld_at != TAPS + 4) begin errors++; $display("FAIL wrap_latency got %0d expected %0d", vld_at, TAPS + 4); end
      checks++; if (got !== 16'hfffe)   begin errors++; $display("FAIL wrap_result got %h expected fffe", got); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < DEPTH; i++) ram[i] = 16'h7fff;
      for (int i = 0; i < TAPS; i++)  coef[i] = 16'h7fff;
      run_sweep(4'd9, -1);
      checks++; if (got !== 16'h7fff) begin errors++; $display("FAIL sat_pos got %h expected 7fff", got); end
      for (int i = 0; i < DEPTH; i++) ram[i] = 16'h8000;
      run_sweep(4'd2, -1);
      checks++; if (got !== 16'h8000) begin errors++; $display("FAIL sat_neg got %h expected 8000", got); end
      checks++; if (vld_cnt != 1)     begin errors++; $display("FAIL sat_vld_count got %0d expected 1", vld_cnt); end
   endtask

   task automatic test_random();
      int            wp;
      logic [DW-1:0] exp_v;
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = DW'($urandom);
            coef[i] = CW'($urandom);
         end
         wp    = $urandom_range(DEPTH - 1);
         exp_v = model_out(wp);
         run_sweep(AW'(wp), -1);
         checks++;
         if (obs_raddr[0] !== AW'(model_start(wp))) begin
            errors++; $display("FAIL rand%0d_start got %0d expected %0d", n, obs_raddr[0], model_start(wp));
         end
         checks++;
         if (vld_at != TAPS + 4 || vld_cnt != 1) begin
            errors++; $display("FAIL rand%0d_vld got at=%0d count=%0d expected at=%0d count=1", n, vld_at, vld_cnt, TAPS + 4);
         end
         checks++;
         if (got !== exp_v) begin
            errors++; $display("FAIL rand%0d_result got %h expected %h (wr_ptr %0d)", n, got, exp_v, wp);
         end
      end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun got %b expected 0", overrun); end
   endtask

   task automatic test_overrun();
      load_basic();
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got %b expected 0", overrun); end
      run_sweep(4'd5, 1);
      checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL ovr_flag got %b expected 1", overrun); end
      checks++; if (vld_cnt != 1)       begin errors++; $display("FAIL ovr_vld_count got %0d expected 1", vld_cnt); end
      checks++; if (vld_at != TAPS + 4) begin errors++; $display("FAIL ovr_latency got %0d expected %0d", vld_at, TAPS + 4); end
      checks++; if (got !== 16'h01f4)   begin errors++; $display("FAIL ovr_result got %h expected 01f4", got); end
   endtask

   task automatic test_reset_mid_sweep();
      int extra_vld;
      extra_vld = 0;
      load_basic();
      @(negedge clk);
      wr_ptr   = 4'd5;
      wrt_smpl = 1'b1;
      @(negedge clk);
      wrt_smpl = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (raddr !== '0)     begin errors++; $display("FAIL midrst_raddr got %h expected 0", raddr); end
      checks++; if (caddr !== '0)     begin errors++; $display("FAIL midrst_caddr got %h expected 0", caddr); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
      checks++; if (smpl_out !== '0)  begin errors++; $display("FAIL midrst_smpl_out got %h expected 0", smpl_out); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got %b expected 0", overrun); end
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 15; j++) begin
         if (vld !== 1'b0) extra_vld++;
         @(negedge clk);
      end
      checks++; if (extra_vld != 0) begin errors++; $display("FAIL midrst_no_vld got %0d pulses expected 0", extra_vld); end
      run_sweep(4'd5, -1);
      checks++; if (got !== 16'h01f4) begin errors++; $display("FAIL midrst_rerun got %h expected 01f4", got); end
      checks++; if (vld_at != TAPS + 4) begin errors++; $display("FAIL midrst_latency got %0d expected %0d", vld_at, TAPS + 4); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      wrt_smpl = 1'b0;
      wr_ptr   = '0;
      q_full   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]  = '0;
         coef[i] = '0;
      end
      test_reset();
      test_no_qfull();
      test_basic();
      test_wrap();
      test_saturation();
      test_random();
      test_overrun();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hif_queue_reader.md
Name: hif_queue_reader

Overview:
- Consumer side of the high-frequency circular sample queue: on every new sample written by the queue writer, sweeps the most recent TAPS samples out of the dual-port RAM read port and multiply-accumulates them against a coefficient ROM.
- Emits one filtered 16-bit sample per written sample.
- Sits between the queue's dual-port RAM (read port) and the downstream sample sink.

Parameters:
- DEPTH, 1536, number of entries in the circular queue.
- AW, 11, address width of queue and coefficient ROM.
- DW, 16, sample width, signed.
- CW, 16, coefficient width, signed Q1.(CW-1).
- TAPS, 1021, samples summed per output; 1 <= TAPS <= DEPTH.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- wrt_smpl  in  1  one-clk pulse: writer has just stored a sample at wr_ptr.
- wr_ptr  in  AW  queue address of the newest sample, valid when wrt_smpl=1.
- q_full  in  1  writer queue has filled at least once (sequencing).
- raddr  out  AW  queue RAM read address; data returns on rdata 1 clk later.
- rdata  in  DW  queue RAM read data.
- caddr  out  AW  coefficient ROM address, 1-clk read latency.
- cdata  in  CW  coefficient data.
- busy  out  1  sweep in progress.
- smpl_out  out  DW  filtered sample, held until next result.
- vld  out  1  one-clk pulse when smpl_out updates.
- overrun  out  1  sticky: trigger arrived while busy.

Behaviour:
- Reset (async, any time including mid-sweep): FSM=IDLE, raddr=0, caddr=0, accumulator=0, pipeline valids=0, busy=0, smpl_out=0, vld=0, overrun=0. Sweep in progress is abandoned; no vld.
- FSM states: IDLE, SWEEP, DRAIN, OUT.
- IDLE -> SWEEP on wrt_smpl=1 && q_full=1.
  - Latch start = (wr_ptr - (TAPS-1)) mod DEPTH.
  - Clear accumulator and tap index.
- wrt_smpl while q_full=0: ignored; no state change, no overrun.
- SWEEP, one address per clk for TAPS clks:
  - raddr = start+i, wrapping DEPTH-1 -> 0; caddr = i.
  - Tap index i=0 pairs the oldest sample with coefficient 0.
  - Go to DRAIN after issuing i=TAPS-1.
- Pipeline stages:
  - address
  - rdata/cdata registered
  - signed product (DW+CW bits) registered
  - accumulate; accumulator is DW+CW+AW bits, no internal overflow possible.
- DRAIN: wait until last product is accumulated, then OUT.
- OUT, one clk:
  - smpl_out = saturate_DW(acc >>> (CW-1)), arithmetic shift (floor).
  - Saturation clamps to 0x7FFF / 0x8000.
  - vld=1; next state IDLE.
- busy=1 in SWEEP, DRAIN and OUT.
- Latency: vld high exactly TAPS+4 clks after the clk edge that sampled wrt_smpl.
- wrt_smpl while busy: ignored, overrun<=1 (cleared only by rst); current sweep unaffected.
- wrt_smpl in the same clk OUT is active: ignored (counts as busy, sets overrun).
- wr_ptr is sampled only at trigger; later changes do not affect the sweep.
- raddr/caddr hold their last value in IDLE.

Test Plan:
All use DEPTH=16, TAPS=4, and a RAM model returning stored data 1 clk after raddr.
1. q_full=0, wrt_smpl pulse -> busy stays 0, no vld, overrun=0.
2. RAM[2..5]=100,200,300,400; all coeffs 0x4000; q_full=1; wrt_smpl with wr_ptr=5 -> raddr sequence 2,3,4,5; vld exactly 8 clks later with smpl_out=500 (0x01F4).
3. Wrap case, wr_ptr=1, RAM[14,15,0,1]=-1,-1,-1,-1, coeffs 0x4000 -> raddr 14,15,0,1; smpl_out=-2 (0xFFFE, floor).
4. Saturation:
   - All samples 0x7FFF, coeffs 0x7FFF -> smpl_out=0x7FFF.
   - All samples 0x8000, coeffs 0x7FFF -> smpl_out=0x8000.
5. Overrun: second wrt_smpl 2 clks after the first -> overrun=1, exactly one vld, result identical to scenario 2.
6. Reset mid-sweep: assert rst 3 clks after trigger -> all outputs 0 immediately, no vld. Then trigger scenario 2 again -> smpl_out=500.
